// File: rtl/i2c_pkg.sv
// Shared types for the I2C target: FSM state encoding and bus bit constants.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_e;

  localparam logic WRITE = 1'b0;
  localparam logic READ  = 1'b1;
  localparam logic ACK   = 1'b0;
  localparam logic NACK  = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// Register-port bundle between the I2C target and the register bank.
interface i2c_target_if;

  logic [7:0] o_reg_addr;
  logic [7:0] o_reg_wdata;
  logic       o_reg_we;
  logic       o_reg_re;
  logic [7:0] i_reg_rdata;
  logic       o_busy;

  modport slave (
    output o_reg_addr,
    output o_reg_wdata,
    output o_reg_we,
    output o_reg_re,
    output o_busy,
    input  i_reg_rdata
  );

  modport master (
    input  o_reg_addr,
    input  o_reg_wdata,
    input  o_reg_we,
    input  o_reg_re,
    input  o_busy,
    output i_reg_rdata
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// Per-line synchroniser with edge detect; I2C_TARGET_GLITCH_FILTER_EN
// inserts a 3-sample majority filter after the synchroniser.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line;
  logic                   prev_q;

  // idle bus is high, so reset to 1 to avoid false edges
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= '1;
    end else begin
      hist_q <= {hist_q[1:0], sync_q[SYNC_STAGES-1]};
    end
  end

  assign line = (hist_q[0] & hist_q[1]) |
                (hist_q[0] & hist_q[2]) |
                (hist_q[1] & hist_q[2]);
`else
  assign line = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= line;
    end
  end

  assign level_o = line;
  assign rise_o  = line & ~prev_q;
  assign fall_o  = ~line & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target, 7-bit address, auto-incrementing 8-bit register pointer.
// Optional input glitch filter: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  i2c_target_if.slave regs
);

  state_e     state_q;
  logic [7:0] shreg_q;
  logic [7:0] ptr_q;
  logic [7:0] wdata_q;
  logic [2:0] bitcnt_q;
  logic       first_q;
  logic       ack_q;
  logic       rw_q;
  logic       load_q;
  logic       arm_q;
  logic       sda_en_q;
  logic       we_q;
  logic       re_q;
  logic       busy_q;

  logic       scl;
  logic       scl_rise;
  logic       scl_fall;
  logic       sda;
  logic       sda_rise;
  logic       sda_fall;
  logic       start;
  logic       stop;
  logic [7:0] rx_byte;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .d_i    (i2c_scl),
    .level_o(scl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .d_i    (i2c_sda),
    .level_o(sda),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  assign start   = sda_fall & scl;
  assign stop    = sda_rise & scl;
  assign rx_byte = {shreg_q[6:0], sda};

  // reset must free the bus without waiting for a clock edge
  assign i2c_sda = (sda_en_q || i_rst) ? 1'bz : 1'b0;

  assign regs.o_reg_addr  = ptr_q;
  assign regs.o_reg_wdata = wdata_q;
  assign regs.o_reg_we    = we_q;
  assign regs.o_reg_re    = re_q;
  assign regs.o_busy      = busy_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      ptr_q    <= '0;
      wdata_q  <= '0;
      bitcnt_q <= '0;
      first_q  <= 1'b0;
      ack_q    <= 1'b0;
      rw_q     <= WRITE;
      load_q   <= 1'b0;
      arm_q    <= 1'b0;
      sda_en_q <= 1'b1;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      re_q <= 1'b0;
      if (we_q) ptr_q <= ptr_q + 8'd1;
      if (start) begin
        state_q  <= ADDR;
        bitcnt_q <= '0;
        sda_en_q <= 1'b1;
        ack_q    <= 1'b0;
        load_q   <= 1'b0;
        arm_q    <= 1'b0;
      end else if (stop) begin
        state_q  <= IDLE;
        sda_en_q <= 1'b1;
        busy_q   <= 1'b0;
        ack_q    <= 1'b0;
        load_q   <= 1'b0;
        arm_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: sda_en_q <= 1'b1;
          ADDR: begin
            if (scl_rise) begin
              shreg_q  <= rx_byte;
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                if (rx_byte[7:1] == TARGET_ADDR) begin
                  state_q <= ADDR_ACK;
                  rw_q    <= rx_byte[0];
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_q) begin
                sda_en_q <= ACK;
                ack_q    <= 1'b1;
              end else begin
                ack_q    <= 1'b0;
                bitcnt_q <= '0;
                if (rw_q == READ) begin
                  re_q    <= 1'b1;
                  load_q  <= 1'b1;
                  arm_q   <= 1'b0;
                  state_q <= RD_DATA;
                end else begin
                  sda_en_q <= 1'b1;
                  first_q  <= 1'b1;
                  state_q  <= WR_DATA;
                end
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shreg_q  <= rx_byte;
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                state_q <= WR_ACK;
                if (first_q) begin
                  ptr_q   <= rx_byte;
                  first_q <= 1'b0;
                end else begin
                  we_q    <= 1'b1;
                  wdata_q <= rx_byte;
                end
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (!ack_q) begin
                sda_en_q <= ACK;
                ack_q    <= 1'b1;
              end else begin
                ack_q    <= 1'b0;
                sda_en_q <= 1'b1;
                bitcnt_q <= '0;
                state_q  <= WR_DATA;
              end
            end
          end
          RD_DATA: begin
            // arm_q: reload came mid-SCL-high, so hold the MSB for the next fall
            if (load_q) begin
              shreg_q <= regs.i_reg_rdata;
              load_q  <= 1'b0;
              if (!arm_q) sda_en_q <= regs.i_reg_rdata[7];
            end else if (scl_fall) begin
              if (arm_q) begin
                sda_en_q <= shreg_q[7];
                arm_q    <= 1'b0;
              end else if (bitcnt_q == 3'd7) begin
                sda_en_q <= 1'b1;
                bitcnt_q <= '0;
                state_q  <= RD_ACK;
              end else begin
                sda_en_q <= shreg_q[6];
                shreg_q  <= {shreg_q[6:0], 1'b0};
                bitcnt_q <= bitcnt_q + 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda == ACK) begin
                ptr_q    <= ptr_q + 8'd1;
                re_q     <= 1'b1;
                load_q   <= 1'b1;
                arm_q    <= 1'b1;
                bitcnt_q <= '0;
                state_q  <= RD_DATA;
              end else begin
                state_q <= WAIT_STOP;
              end
            end
          end
          WAIT_STOP: sda_en_q <= 1'b1;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: write, repeated-START read, mismatch,
// pointer wrap, mid-byte STOP, reset during read and SCL glitch.
module tb_i2c_target;

  localparam int HALF = 10;

  logic clk = 1'b0;
  logic rst;
  logic scl;
  logic sda_low;
  wire  sda_bus;

  int nchk = 0;
  int npass = 0;

  int we_cnt = 0;
  int re_cnt = 0;
  int both_cnt = 0;
  int low_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] we_a [0:15];
  logic [7:0] we_d [0:15];

  i2c_target_if rif ();

  assign sda_bus = sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  always_comb begin
    rif.i_reg_rdata = 8'h00;
    if (rif.o_reg_addr == 8'h10) rif.i_reg_rdata = 8'h77;
    if (rif.o_reg_addr == 8'h11) rif.i_reg_rdata = 8'h88;
  end

  i2c_target #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i2c_scl(scl),
    .i2c_sda(sda_bus),
    .regs   (rif)
  );

  always @(negedge clk) begin
    if (rif.o_reg_we) begin
      if (we_cnt < 16) begin
        we_a[we_cnt] <= rif.o_reg_addr;
        we_d[we_cnt] <= rif.o_reg_wdata;
      end
      we_cnt <= we_cnt + 1;
    end
    if (rif.o_reg_re) re_cnt <= re_cnt + 1;
    if (rif.o_reg_we && rif.o_reg_re) both_cnt <= both_cnt + 1;
    if (sda_bus === 1'b0 && !sda_low) low_cnt <= low_cnt + 1;
    if (rif.o_busy) busy_cnt <= busy_cnt + 1;
  end

  function automatic logic bus_rd();
    return (sda_bus === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (!scl) begin
      sda_low = 1'b0;
      wait_clk(HALF);
      scl = 1'b1;
      wait_clk(HALF);
    end
    sda_low = 1'b1;
    wait_clk(HALF);
    scl = 1'b0;
    wait_clk(3);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1;
    wait_clk(HALF);
    scl = 1'b1;
    wait_clk(HALF);
    sda_low = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic send_bit(input logic b);
    sda_low = ~b;
    wait_clk(HALF);
    scl = 1'b1;
    wait_clk(HALF);
    scl = 1'b0;
    wait_clk(3);
  endtask

  task automatic get_ack(output logic ack);
    sda_low = 1'b0;
    wait_clk(HALF);
    scl = 1'b1;
    wait_clk(HALF / 2);
    ack = bus_rd();
    wait_clk(HALF / 2);
    scl = 1'b0;
    wait_clk(3);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    get_ack(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    d = 8'h00;
    sda_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_clk(HALF);
      scl = 1'b1;
      wait_clk(HALF / 2);
      d = {d[6:0], bus_rd()};
      wait_clk(HALF / 2);
      scl = 1'b0;
      wait_clk(3);
    end
    send_bit(nack);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         w0;
    int         r0;
    int         l0;
    int         b0;

    rst = 1'b1;
    scl = 1'b1;
    sda_low = 1'b0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);
    chk("rst_addr", rif.o_reg_addr, 8'h00);
    chk("rst_busy", rif.o_busy, 1'b0);
    chk("rst_we", rif.o_reg_we, 1'b0);
    chk("rst_re", rif.o_reg_re, 1'b0);
    chk("rst_sda", bus_rd(), 1'b1);

    // write 0x5A,0x3C starting at 0x10
    w0 = we_cnt;
    i2c_start();
    send_byte(8'hA0, a); chk("wr_ack_addr", a, 1'b0);
    send_byte(8'h10, a); chk("wr_ack_ptr", a, 1'b0);
    send_byte(8'h5A, a); chk("wr_ack_d0", a, 1'b0);
    send_byte(8'h3C, a); chk("wr_ack_d1", a, 1'b0);
    chk("wr_busy", rif.o_busy, 1'b1);
    i2c_stop();
    chk("wr_we_cnt", we_cnt - w0, 2);
    chk("wr0_addr", we_a[w0], 8'h10);
    chk("wr0_data", we_d[w0], 8'h5A);
    chk("wr1_addr", we_a[w0+1], 8'h11);
    chk("wr1_data", we_d[w0+1], 8'h3C);
    chk("wr_ptr_end", rif.o_reg_addr, 8'h12);
    chk("wr_busy_end", rif.o_busy, 1'b0);

    // repeated-START read of 0x10,0x11
    w0 = we_cnt;
    r0 = re_cnt;
    i2c_start();
    send_byte(8'hA0, a); chk("rd_ack_waddr", a, 1'b0);
    send_byte(8'h10, a); chk("rd_ack_ptr", a, 1'b0);
    i2c_start();
    send_byte(8'hA1, a); chk("rd_ack_raddr", a, 1'b0);
    read_byte(1'b0, d); chk("rd_byte0", d, 8'h77);
    read_byte(1'b1, d); chk("rd_byte1", d, 8'h88);
    i2c_stop();
    chk("rd_re_cnt", re_cnt - r0, 2);
    chk("rd_we_cnt", we_cnt - w0, 0);
    chk("rd_busy_end", rif.o_busy, 1'b0);

    // address mismatch
    w0 = we_cnt;
    r0 = re_cnt;
    l0 = low_cnt;
    b0 = busy_cnt;
    i2c_start();
    send_byte(8'hB0, a); chk("mm_ack_addr", a, 1'b1);
    send_byte(8'hFF, a); chk("mm_ack_data", a, 1'b1);
    i2c_stop();
    chk("mm_sda_low", low_cnt - l0, 0);
    chk("mm_we", we_cnt - w0, 0);
    chk("mm_re", re_cnt - r0, 0);
    chk("mm_busy", busy_cnt - b0, 0);

    // pointer wrap 0xFF -> 0x00
    w0 = we_cnt;
    i2c_start();
    send_byte(8'hA0, a);
    send_byte(8'hFF, a);
    send_byte(8'h01, a);
    send_byte(8'h02, a);
    i2c_stop();
    chk("wrap_cnt", we_cnt - w0, 2);
    chk("wrap0_addr", we_a[w0], 8'hFF);
    chk("wrap0_data", we_d[w0], 8'h01);
    chk("wrap1_addr", we_a[w0+1], 8'h00);
    chk("wrap1_data", we_d[w0+1], 8'h02);
    chk("wrap_ptr", rif.o_reg_addr, 8'h01);

    // STOP after 4 data bits
    w0 = we_cnt;
    i2c_start();
    send_byte(8'hA0, a);
    send_byte(8'h20, a);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    i2c_stop();
    chk("part_we", we_cnt - w0, 0);
    chk("part_busy", rif.o_busy, 1'b0);
    chk("part_ptr", rif.o_reg_addr, 8'h20);

    // reset while driving a 0 data bit
    i2c_start();
    send_byte(8'hA0, a);
    send_byte(8'h40, a);
    i2c_start();
    send_byte(8'hA1, a); chk("rr_ack", a, 1'b0);
    wait_clk(8);
    chk("rr_sda_drv", bus_rd(), 1'b0);
    chk("rr_busy", rif.o_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rr_sda_now", bus_rd(), 1'b1);
    wait_clk(1);
    chk("rr_sda_next", bus_rd(), 1'b1);
    chk("rr_ptr", rif.o_reg_addr, 8'h00);
    chk("rr_busy_rst", rif.o_busy, 1'b0);
    scl = 1'b1;
    sda_low = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);

    // one-cycle SCL low pulse during the first address bit
    i2c_start();
    sda_low = 1'b0;
    wait_clk(HALF);
    scl = 1'b1;
    wait_clk(4);
    scl = 1'b0;
    wait_clk(1);
    scl = 1'b1;
    wait_clk(HALF - 5);
    scl = 1'b0;
    wait_clk(3);
    for (int i = 6; i >= 0; i--) send_bit(i == 5);
    get_ack(a);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    chk("glitch_ack", a, 1'b0);
`else
    chk("glitch_ack", a, 1'b1);
`endif
    i2c_stop();
    chk("glitch_busy", rif.o_busy, 1'b0);

    chk("strobe_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
